// File: rtl/data_cache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped, write-through data cache.
// Line layout: valid, tag (zero-extended line-address bits above the index), 4 words.
package data_cache_ctrl_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int LINE_WORDS      = 4;
    localparam int MEM_LATENCY_DEF = 5;
    localparam int ADDR_W          = 16;
    localparam int LINE_W          = WORD_SIZE * LINE_WORDS;
    localparam int TAG_W           = ADDR_W - 2;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } state_t;

    typedef struct packed {
        logic                        valid;
        logic [TAG_W-1:0]            tag;
        word_t [LINE_WORDS-1:0]      words;
    } line_t;

endpackage

// File: rtl/data_cache_ctrl_if.sv
// CPU load/store request interface; master is the datapath, slave is the cache.
// Requests are held by the master until the one-cycle cpu_ready pulse.
interface data_cache_ctrl_if;
    import data_cache_ctrl_pkg::*;

    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    word_t             cpu_wdata;
    word_t             cpu_rdata;
    logic              cpu_ready;

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_wdata,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_wdata,
        output cpu_rdata, cpu_ready
    );

endinterface

// File: rtl/data_cache_ctrl_cache_line_array.sv
// Tag/valid/data storage: combinational lookup, synchronous install, word update and valid clear.
// Lookup is zero-latency; install and update take effect on the next edge.
module cache_line_array
    import data_cache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output word_t             word_o,
    input  logic              install_i,
    input  logic [ADDR_W-3:0] install_laddr_i,
    input  logic [LINE_W-1:0] install_data_i,
    input  logic              update_i,
    input  logic [ADDR_W-1:0] update_addr_i,
    input  word_t             update_word_i
);

    localparam int IDX_W = $clog2(NUM_LINES);

    line_t lines_q [NUM_LINES];
    line_t cur_line;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-3:0] laddr);
        return laddr[IDX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-3:0] laddr);
        return laddr >> IDX_W;
    endfunction

    assign cur_line = lines_q[idx_of(lookup_addr_i[ADDR_W-1:2])];
    assign hit_o    = cur_line.valid && (cur_line.tag == tag_of(lookup_addr_i[ADDR_W-1:2]));
    assign word_o   = cur_line.words[lookup_addr_i[1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_q[i].valid <= 1'b0;
            end
        end else begin
            // Conflicting index is simply overwritten: memory already holds every store.
            if (install_i) begin
                lines_q[idx_of(install_laddr_i)].valid <= 1'b1;
                lines_q[idx_of(install_laddr_i)].tag   <= tag_of(install_laddr_i);
                lines_q[idx_of(install_laddr_i)].words <= install_data_i;
            end
            if (update_i) begin
                lines_q[idx_of(update_addr_i[ADDR_W-1:2])].words[update_addr_i[1:0]] <= update_word_i;
            end
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through data cache: 1-cycle read hits, MEM_LATENCY+2 strobe cycles per fill/write, then RESP.
// CPU holds requests until cpu_ready; optional hit/miss counters under DATA_CACHE_STATS_EN.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int NUM_LINES   = 4,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    data_cache_ctrl_if.slave  cpu,
    output logic              readM,
    output logic              writeM,
    output logic [ADDR_W-1:0] address,
    inout  wire  [LINE_W-1:0] data
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [15:0]       num_hit,
    output logic [15:0]       num_miss
`endif
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 3);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY + 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    word_t             wdata_q;
    word_t             rdata_q;
    logic              ready_q;

    logic              hit;
    word_t             hit_word;
    logic [ADDR_W-1:0] lookup_addr;
    logic              req_vld;
    logic              last_beat;
    word_t [LINE_WORDS-1:0] fill_words;

    // The cycle after a completion the CPU still shows the old request, so it is ignored.
    assign req_vld     = (cpu.cpu_read || cpu.cpu_write) && !ready_q;
    assign lookup_addr = (state_q == IDLE) ? cpu.cpu_address : addr_q;
    assign last_beat   = (cnt_q == '0);
    assign fill_words  = data;

    assign data          = writeM ? {{(LINE_W-WORD_SIZE){1'b0}}, wdata_q} : {LINE_W{1'bz}};
    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_ready = ready_q;

    cache_line_array #(.NUM_LINES(NUM_LINES)) u_lines (
        .clk             (clk),
        .reset           (reset),
        .lookup_addr_i   (lookup_addr),
        .hit_o           (hit),
        .word_o          (hit_word),
        .install_i       (state_q == FILL && last_beat),
        .install_laddr_i (addr_q[ADDR_W-1:2]),
        .install_data_i  (data),
        .update_i        (state_q == WRITE && last_beat && hit),
        .update_addr_i   (addr_q),
        .update_word_i   (wdata_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            readM   <= 1'b0;
            writeM  <= 1'b0;
            address <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_vld && cpu.cpu_read) begin
                        if (hit) begin
                            rdata_q <= hit_word;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            readM   <= 1'b1;
                            address <= {cpu.cpu_address[ADDR_W-1:2], 2'b00};
                            addr_q  <= cpu.cpu_address;
                            cnt_q   <= CNT_LOAD;
                        end
                    end else if (req_vld && cpu.cpu_write) begin
                        state_q <= WRITE;
                        writeM  <= 1'b1;
                        address <= cpu.cpu_address;
                        addr_q  <= cpu.cpu_address;
                        wdata_q <= cpu.cpu_wdata;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                FILL: begin
                    if (last_beat) begin
                        readM   <= 1'b0;
                        rdata_q <= fill_words[addr_q[1:0]];
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WRITE: begin
                    if (last_beat) begin
                        writeM  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && req_vld) begin
            if (hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign num_hit  = hit_cnt_q;
    assign num_miss = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: fixed-latency memory model plus a reference cache/memory model;
// expected load data is queued at issue and popped when cpu_ready arrives.
module tb_data_cache_ctrl;
    import data_cache_ctrl_pkg::*;

    localparam int LAT = 5;
    localparam int NL  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_cache_ctrl_if cpu_if ();

    logic        readM;
    logic        writeM;
    logic [15:0] address;
    wire  [63:0] data;
    logic [63:0] mem_drv = '0;
    logic        mem_oe  = 1'b0;

    assign data = mem_oe ? mem_drv : 64'bz;

`ifdef DATA_CACHE_STATS_EN
    logic [15:0] num_hit;
    logic [15:0] num_miss;
`endif

    data_cache_ctrl #(.NUM_LINES(NL), .MEM_LATENCY(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .cpu     (cpu_if),
        .readM   (readM),
        .writeM  (writeM),
        .address (address),
        .data    (data)
`ifdef DATA_CACHE_STATS_EN
        ,
        .num_hit  (num_hit),
        .num_miss (num_miss)
`endif
    );

    // Memory: contents land on the bus for the edge LAT+2 cycles after the strobe rises.
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    int          rcnt       = 0;
    int          wcnt       = 0;
    bit          init_phase = 1'b1;

    function automatic logic [15:0] init_word(input int i);
        if (i >= 32 && i <= 34) return 16'h0000;
        if (i == 35)            return 16'h6000;
        return 16'(32'hA000 + i * 7);
    endfunction

    always @(negedge clk) begin
        if (reset && init_phase) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end
        rcnt    <= readM ? rcnt + 1 : 0;
        mem_oe  <= readM && (rcnt + 1 == LAT + 2);
        mem_drv <= {mem[address[7:0] + 8'd3], mem[address[7:0] + 8'd2],
                    mem[address[7:0] + 8'd1], mem[address[7:0]]};
        wcnt    <= writeM ? wcnt + 1 : 0;
        if (writeM && (wcnt + 1 == LAT + 2)) mem[address[7:0]] <= data[15:0];
    end

    bit          ref_valid [NL];
    logic [11:0] ref_tag   [NL];
    logic [15:0] exp_q     [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input bit wr, input logic [15:0] a, input logic [15:0] wd);
        logic [1:0]  idx;
        bit          exp_hit;
        int          exp_lat;
        int          lat;
        int          rc;
        int          wc;
        bit          seen;
        bit          got_addr;
        logic [15:0] addr_seen;
        logic [63:0] data_seen;
        logic [15:0] exp_addr;
        logic [15:0] exp_word;

        idx     = a[3:2];
        exp_hit = ref_valid[idx] && (ref_tag[idx] == a[15:4]);
        if (wr) begin
            ref_mem[a[7:0]] = wd;
            exp_lat  = 8;
            exp_addr = a;
        end else begin
            exp_q.push_back(ref_mem[a[7:0]]);
            exp_lat  = exp_hit ? 1 : 8;
            exp_addr = {a[15:2], 2'b00};
            if (!exp_hit) begin
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = a[15:4];
            end
        end

        @(negedge clk);
        cpu_if.cpu_read    = !wr;
        cpu_if.cpu_write   = wr;
        cpu_if.cpu_address = a;
        cpu_if.cpu_wdata   = wd;
        lat = 0; rc = 0; wc = 0; seen = 1'b0; got_addr = 1'b0;
        addr_seen = '0; data_seen = '0;
        while (!seen && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (readM) rc++;
            if (writeM) wc++;
            if ((readM || writeM) && !got_addr) begin
                got_addr  = 1'b1;
                addr_seen = address;
                data_seen = data;
            end
            if (cpu_if.cpu_ready) begin
                seen = 1'b1;
                check("ready_vs_strobe", {62'b0, readM, writeM}, 64'd0);
            end
        end
        cpu_if.cpu_read  = 1'b0;
        cpu_if.cpu_write = 1'b0;

        check("ready_seen", seen, 1);
        check(wr ? "wr_latency" : (exp_hit ? "rd_hit_latency" : "rd_miss_latency"), lat, exp_lat);
        check("readM_cycles", rc, (!wr && !exp_hit) ? 7 : 0);
        check("writeM_cycles", wc, wr ? 7 : 0);
        if (wr || !exp_hit) check("mem_address", addr_seen, exp_addr);
        if (wr) begin
            check("write_bus_data", data_seen, {48'b0, wd});
        end else if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            check("rd_data", cpu_if.cpu_rdata, exp_word);
        end
        @(posedge clk);
        if (wr) check("mem_word_updated", mem[a[7:0]], wd);
    endtask

    initial begin
        int rdy;
        cpu_if.cpu_read    = 1'b0;
        cpu_if.cpu_write   = 1'b0;
        cpu_if.cpu_address = '0;
        cpu_if.cpu_wdata   = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < NL; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_readM", readM, 0);
        check("rst_writeM", writeM, 0);
        check("rst_ready", cpu_if.cpu_ready, 0);
        check("rst_address", address, 0);
        check("rst_rdata", cpu_if.cpu_rdata, 0);
        @(negedge clk);
        reset      = 1'b0;
        init_phase = 1'b0;

        do_op(0, 16'h0000, 0);
        do_op(0, 16'h0023, 0);
        do_op(0, 16'h0021, 0);
        do_op(1, 16'h0022, 16'hBEEF);
        do_op(0, 16'h0022, 0);
        do_op(1, 16'h0040, 16'h1234);
        do_op(0, 16'h0040, 0);
        do_op(0, 16'h0030, 0);
        do_op(0, 16'h0023, 0);
        do_op(0, 16'h0031, 0);

        for (int n = 0; n < 14; n++) begin
            do_op($urandom_range(0, 2) == 0, 16'($urandom_range(0, 63)), 16'($urandom));
        end

        // Reset in the middle of a fill
        @(negedge clk);
        cpu_if.cpu_read    = 1'b1;
        cpu_if.cpu_address = 16'h0050;
        repeat (3) @(posedge clk);
        #1;
        check("mf_readM_on", readM, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mf_readM_drop", readM, 0);
        check("mf_ready_low", cpu_if.cpu_ready, 0);
        @(negedge clk);
        reset           = 1'b0;
        cpu_if.cpu_read = 1'b0;
        rdy = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (cpu_if.cpu_ready) rdy++;
        end
        check("mf_no_ready", rdy, 0);
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
        do_op(0, 16'h0050, 0);
        do_op(0, 16'h0052, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
